// File: rtl/apb_slave_regfile_pkg.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile_pkg
// Shared definitions for the APB bridge slice:
//   - slave FSM state encoding (IDLE / ACCESS)
//   - bridge-side phase encodings (Idle / Setup / Access)
//   - APB response codes (OKAY, SLVERR = 2'b10)
//   - wait-counter width
//   - apb_decode(): byte address -> {hit, register index}
// -----------------------------------------------------------------------------
package apb_slave_regfile_pkg;

  // Slave-side transfer FSM
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } slv_state_t;

  // Bridge-side APB phase encoding, shared with the master side of the bridge
  typedef enum logic [1:0] {
    BR_IDLE   = 2'b00,
    BR_SETUP  = 2'b01,
    BR_ACCESS = 2'b10
  } br_state_t;

  // Response codes; the slave maps SLVERR onto the single pslverr wire
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Wait counter width: holds 0..15 wait states
  localparam int WCNT_W = 4;

  typedef struct packed {
    logic       hit;
    logic [5:0] idx;
  } dec_t;

  // Offset is computed modulo 2^32, so addresses below the base wrap to a
  // large offset and fall outside the window instead of aliasing.
  function automatic dec_t apb_decode(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          nregs);
    logic [31:0] off;
    logic [31:0] lim;
    dec_t        d;
    off   = addr - base;
    lim   = 32'(nregs) << 2;
    d.hit = (off < lim) && (off[1:0] == 2'b00);
    d.idx = off[7:2];
    return d;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// -----------------------------------------------------------------------------
// apb_wait_counter
// Wait-state counter for the APB slave access phase. Loads WAIT_STATES on the
// setup cycle and counts down while the master holds the access phase.
// Ports:
//   s_axi_clk      in   clock, rising edge
//   s_axi_aresetn  in   asynchronous active-low reset
//   i_load         in   load WAIT_STATES (setup cycle accepted)
//   i_dec          in   decrement request (access phase, not yet ready)
//   o_zero         out  counter is zero (access may complete)
// -----------------------------------------------------------------------------
module apb_wait_counter
  import apb_slave_regfile_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic s_axi_clk,
  input  logic s_axi_aresetn,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  logic [WCNT_W-1:0] r_wcnt;

  // Load has priority so a fresh setup always restarts the count, even after
  // an aborted transfer left a residual value behind.
  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wcnt <= '0;
    end else if (i_load) begin
      r_wcnt <= WCNT_W'(WAIT_STATES);
    end else if (i_dec && (r_wcnt != '0)) begin
      r_wcnt <= r_wcnt - WCNT_W'(1);
    end
  end

  assign o_zero = (r_wcnt == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
// APB slave exposing NUM_REGS 32-bit registers at BASE_ADDR, with a fixed
// number of wait states per access, byte strobes, and per-register read-only
// selection (read-only registers return hw_in and reject writes with pslverr).
// Ports:
//   s_axi_clk      in   clock, rising edge
//   s_axi_aresetn  in   asynchronous active-low reset
//   psel, penable  in   APB select / access strobe
//   pwrite         in   1 = write, 0 = read
//   paddr          in   byte address
//   pwdata, pstrb  in   write data and byte enables
//   pprot          in   protection attributes (ignored)
//   pready         out  transfer complete (combinational)
//   prdata         out  read data, zero outside a successful read
//   pslverr        out  transfer error, only together with pready
//   hw_in          in   read values for read-only registers, 32 bits each
//   reg_out        out  register array contents, 32 bits each
//   wr_pulse       out  one-cycle strobe per register after a committed write
// -----------------------------------------------------------------------------
module apb_slave_regfile
  import apb_slave_regfile_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2,
  parameter logic [63:0] RO_MASK     = 64'h0
) (
  input  logic                  s_axi_clk,
  input  logic                  s_axi_aresetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           paddr,
  input  logic [31:0]           pwdata,
  input  logic [3:0]            pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic [31:0]           prdata,
  output logic                  pslverr,
  input  logic [32*NUM_REGS-1:0] hw_in,
  output logic [32*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]   wr_pulse
);

  slv_state_t  r_state;
  slv_state_t  w_next_state;

  // Transfer attributes captured on the setup cycle
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic        r_write;

  logic        w_setup;
  logic        w_access_ph;
  logic        w_load;
  logic        w_dec;
  logic        w_zero;
  logic        w_pready;
  logic        w_err;
  logic        w_ro;
  logic        w_commit;
  logic [1:0]  w_resp;
  logic [31:0] w_rdata;
  dec_t        w_decode;
  logic        w_unused_pprot;

  assign w_setup     = psel & ~penable;
  assign w_access_ph = psel & penable;

  // Decode works only on captured values so bus changes after setup are inert
  assign w_decode = apb_decode(r_addr, BASE_ADDR, NUM_REGS);
  assign w_ro     = RO_MASK[w_decode.idx];

  // Protection attributes have no effect on this register file
  assign w_unused_pprot = ^pprot;

  apb_wait_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_counter (
    .s_axi_clk     (s_axi_clk),
    .s_axi_aresetn (s_axi_aresetn),
    .i_load        (w_load),
    .i_dec         (w_dec),
    .o_zero        (w_zero)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Losing psel mid-transfer is an abort; completion also returns to
        // IDLE so a setup in the very next cycle is accepted without a gap.
        if (!psel || w_pready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pready = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load = w_setup;
      end
      ST_ACCESS: begin
        w_pready = w_access_ph & w_zero;
        w_dec    = w_access_ph & ~w_zero;
      end
      default: ;
    endcase
  end

  // Setup-cycle capture; contents only matter once ACCESS is entered
  always_ff @(posedge s_axi_clk) begin
    if (w_load) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
    end
  end

  assign w_err    = w_pready & (~w_decode.hit | (r_write & w_ro));
  assign w_resp   = w_err ? RESP_SLVERR : RESP_OKAY;
  assign w_commit = w_pready & r_write & ~w_err;

  // Read-only registers are served from hw_in; the array copy is never written
  always_comb begin
    w_rdata = 32'h0;
    if (w_pready && !r_write && w_decode.hit) begin
      if (w_ro) begin
        w_rdata = hw_in[{w_decode.idx, 5'b0} +: 32];
      end else begin
        w_rdata = reg_out[{w_decode.idx, 5'b0} +: 32];
      end
    end
  end

  assign pready  = w_pready;
  assign pslverr = (w_resp == RESP_SLVERR);
  assign prdata  = w_rdata;

  // ---------------------------------------------------------------------------
  // Register array and write strobes
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [31:0] r_data;
    logic        r_pulse;
    logic        w_sel;

    assign w_sel = w_commit && (w_decode.idx == 6'(gi));

    // An all-zero strobe still selects the register, so the pulse fires
    // while no byte changes.
    always_ff @(posedge s_axi_clk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        r_data  <= 32'h0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_sel;
        if (w_sel) begin
          for (int k = 0; k < 4; k++) begin
            if (r_strb[k]) begin
              r_data[8*k +: 8] <= r_wdata[8*k +: 8];
            end
          end
        end
      end
    end

    assign reg_out[32*gi +: 32] = r_data;
    assign wr_pulse[gi]         = r_pulse;
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_regfile
// Self-checking bench for apb_slave_regfile. Main instance: 16 registers at a
// non-zero base, 2 wait states, register 3 read-only. Second instance: zero
// wait states for back-to-back transfers. Expected responses are queued when a
// transfer is launched and popped when pready is observed.
// -----------------------------------------------------------------------------
module tb_apb_slave_regfile;

  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int          WS   = 2;
  localparam logic [63:0] ROM  = 64'h0000_0000_0000_0008;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic            psel, penable, pwrite;
  logic [31:0]     paddr, pwdata;
  logic [3:0]      pstrb;
  logic [2:0]      pprot;
  logic            pready, pslverr;
  logic [31:0]     prdata;
  logic [32*NR-1:0] hw_in, reg_out;
  logic [NR-1:0]   wr_pulse;

  // Zero-wait-state instance
  logic            b_psel, b_penable, b_pwrite;
  logic [31:0]     b_paddr, b_pwdata;
  logic [3:0]      b_pstrb;
  logic [2:0]      b_pprot;
  logic            b_pready, b_pslverr;
  logic [31:0]     b_prdata;
  logic [32*NR-1:0] b_hw_in, b_reg_out;
  logic [NR-1:0]   b_wr_pulse;

  apb_slave_regfile #(
    .NUM_REGS (NR), .BASE_ADDR (BASE), .WAIT_STATES (WS), .RO_MASK (ROM)
  ) u_dut (
    .s_axi_clk (clk), .s_axi_aresetn (rstn),
    .psel (psel), .penable (penable), .pwrite (pwrite), .paddr (paddr),
    .pwdata (pwdata), .pstrb (pstrb), .pprot (pprot),
    .pready (pready), .prdata (prdata), .pslverr (pslverr),
    .hw_in (hw_in), .reg_out (reg_out), .wr_pulse (wr_pulse)
  );

  apb_slave_regfile #(
    .NUM_REGS (NR), .BASE_ADDR (32'h0), .WAIT_STATES (0), .RO_MASK (64'h0)
  ) u_dut0 (
    .s_axi_clk (clk), .s_axi_aresetn (rstn),
    .psel (b_psel), .penable (b_penable), .pwrite (b_pwrite), .paddr (b_paddr),
    .pwdata (b_pwdata), .pstrb (b_pstrb), .pprot (b_pprot),
    .pready (b_pready), .prdata (b_prdata), .pslverr (b_pslverr),
    .hw_in (b_hw_in), .reg_out (b_reg_out), .wr_pulse (b_wr_pulse)
  );

  typedef struct {
    logic [31:0]   rdata;
    logic          err;
    logic [NR-1:0] pulse;
    int            lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [NR];
  logic [31:0] last_rdata;
  logic        last_err;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [32*NR-1:0] model_flat();
    logic [32*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  // One complete transfer on the main instance. With scramble set the address,
  // direction, data and strobes are corrupted after the setup cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input bit scramble, input string name);
    exp_t        e;
    logic [31:0] off;
    logic        hit, ro;
    int          idx, cyc;
    off = addr - BASE;
    hit = (off < 32'd64) && (off[1:0] == 2'b00);
    idx = hit ? int'(off[5:2]) : 0;
    ro  = hit && ROM[idx];
    e.err   = !hit || (wr && ro);
    e.rdata = 32'h0;
    if (!wr && hit) e.rdata = ro ? hw_in[32*idx +: 32] : model[idx];
    e.pulse = '0;
    if (wr && !e.err) begin
      e.pulse[idx] = 1'b1;
      for (int k = 0; k < 4; k++)
        if (strb[k]) model[idx][8*k +: 8] = wdata[8*k +: 8];
    end
    e.lat = WS + 1;
    sb_q.push_back(e);

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    if (scramble) begin
      pwrite = ~wr; paddr = addr ^ 32'h0000_0004; pwdata = ~wdata; pstrb = ~strb;
    end
    cyc = 1;
    @(negedge clk);
    while (pready !== 1'b1 && cyc < 20) begin
      n_tests++;
      if (pslverr !== 1'b0 || prdata !== 32'h0) begin
        n_fail++;
        $display("FAIL %s wait_idle: pslverr=%b prdata=%h, required 0 and 0 (cycle %0d)",
                 name, pslverr, prdata, cyc);
      end
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    n_tests++;
    if (pready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: pready=%b after %0d cycles, required 1", name, pready, cyc);
    end else begin
      if (cyc != e.lat) begin
        n_fail++;
        $display("FAIL %s latency: pready after %0d cycles, required %0d", name, cyc, e.lat);
      end
      n_tests++;
      if (pslverr !== e.err) begin
        n_fail++;
        $display("FAIL %s pslverr: got %b, required %b", name, pslverr, e.err);
      end
      n_tests++;
      if (prdata !== e.rdata) begin
        n_fail++;
        $display("FAIL %s prdata: got %h, required %h", name, prdata, e.rdata);
      end
    end
    last_rdata = prdata;
    last_err   = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_tests++;
    if (wr_pulse !== e.pulse) begin
      n_fail++;
      $display("FAIL %s wr_pulse: got %h, required %h", name, wr_pulse, e.pulse);
    end
    n_tests++;
    if (reg_out !== model_flat()) begin
      n_fail++;
      $display("FAIL %s reg_out: got %h, required %h", name, reg_out, model_flat());
    end
    @(negedge clk);
    n_tests++;
    if (wr_pulse !== '0) begin
      n_fail++;
      $display("FAIL %s wr_pulse_width: got %h one cycle later, required 0", name, wr_pulse);
    end
  endtask

  task automatic test_reset();
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pprot = 3'b010;
    b_psel = 0; b_penable = 0; b_pwrite = 0; b_paddr = 0; b_pwdata = 0; b_pstrb = 0;
    b_pprot = 3'b000; b_hw_in = '0;
    for (int i = 0; i < NR; i++) begin
      hw_in[32*i +: 32] = 32'hCAFE_0000 | i;
      model[i] = 32'h0;
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    n_tests++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: pready=%b pslverr=%b prdata=%h, required 0/0/0",
               pready, pslverr, prdata);
    end
    n_tests++;
    if (reg_out !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: reg_out=%h, required 0", reg_out);
    end
    n_tests++;
    if (wr_pulse !== '0 || b_wr_pulse !== '0 || b_reg_out !== '0) begin
      n_fail++;
      $display("FAIL reset_misc: wr_pulse=%h b_wr_pulse=%h b_reg_out nonzero=%b, required 0",
               wr_pulse, b_wr_pulse, |b_reg_out);
    end
  endtask

  task automatic test_full_write();
    apb_xfer(1'b1, BASE + 32'h8, 32'hA5A5_1234, 4'hF, 1'b0, "full_write");
    n_tests++;
    if (reg_out[95:64] !== 32'hA5A5_1234) begin
      n_fail++;
      $display("FAIL full_write_reg2: got %h, required a5a51234", reg_out[95:64]);
    end
  endtask

  task automatic test_strobes();
    apb_xfer(1'b1, BASE + 32'h4, 32'h1122_3344, 4'hF, 1'b0, "strb_init");
    apb_xfer(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'b0101, 1'b0, "strb_partial");
    n_tests++;
    if (reg_out[63:32] !== 32'h11FF_33FF) begin
      n_fail++;
      $display("FAIL strb_reg1: got %h, required 11ff33ff", reg_out[63:32]);
    end
    apb_xfer(1'b0, BASE + 32'h4, 32'h0, 4'h0, 1'b0, "strb_read");
    n_tests++;
    if (last_rdata !== 32'h11FF_33FF) begin
      n_fail++;
      $display("FAIL strb_readback: got %h, required 11ff33ff", last_rdata);
    end
    apb_xfer(1'b1, BASE + 32'h4, 32'h0000_0000, 4'h0, 1'b0, "strb_zero");
    n_tests++;
    if (reg_out[63:32] !== 32'h11FF_33FF || last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL strb_zero_noop: reg1=%h err=%b, required 11ff33ff and 0",
               reg_out[63:32], last_err);
    end
  endtask

  task automatic test_errors();
    apb_xfer(1'b1, BASE + 32'h40, 32'hDEAD_0040, 4'hF, 1'b0, "err_range_wr");
    apb_xfer(1'b0, BASE + 32'h40, 32'h0, 4'h0, 1'b0, "err_range_rd");
    apb_xfer(1'b1, BASE + 32'h6, 32'hDEAD_0006, 4'hF, 1'b0, "err_align_wr");
    apb_xfer(1'b0, BASE + 32'h6, 32'h0, 4'h0, 1'b0, "err_align_rd");
    n_tests++;
    if (last_err !== 1'b1 || last_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL err_align_resp: err=%b prdata=%h, required 1 and 0", last_err, last_rdata);
    end
    apb_xfer(1'b1, BASE - 32'h4, 32'hDEAD_FFFC, 4'hF, 1'b0, "err_below_base");
  endtask

  task automatic test_readonly();
    apb_xfer(1'b1, BASE + 32'hC, 32'h1234_5678, 4'hF, 1'b0, "ro_write");
    n_tests++;
    if (last_err !== 1'b1 || reg_out[127:96] !== 32'h0) begin
      n_fail++;
      $display("FAIL ro_write_reject: err=%b reg3=%h, required 1 and 0", last_err, reg_out[127:96]);
    end
    apb_xfer(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b0, "ro_read");
    n_tests++;
    if (last_rdata !== 32'hCAFE_0003) begin
      n_fail++;
      $display("FAIL ro_read_value: got %h, required cafe0003", last_rdata);
    end
  endtask

  task automatic test_capture();
    apb_xfer(1'b1, BASE + 32'h1C, 32'h0BAD_F00D, 4'hF, 1'b1, "capture_wr");
    apb_xfer(1'b0, BASE + 32'h1C, 32'h0, 4'h0, 1'b1, "capture_rd");
    n_tests++;
    if (last_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL capture_readback: got %h, required 0badf00d", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 1;
    e.pulse = 16'h0001; sb_q.push_back(e);
    e.pulse = 16'h0008; sb_q.push_back(e);
    @(posedge clk); #1;
    b_psel = 1; b_penable = 0; b_pwrite = 1; b_paddr = 32'h0; b_pwdata = 32'h1357_9BDF; b_pstrb = 4'hF;
    @(negedge clk);
    n_tests++;
    if (b_pready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_setup1: pready=%b, required 0", b_pready);
    end
    @(posedge clk); #1 b_penable = 1;
    @(negedge clk);
    e = sb_q.pop_front();
    n_tests++;
    if (b_pready !== 1'b1 || b_pslverr !== e.err || b_prdata !== e.rdata) begin
      n_fail++;
      $display("FAIL b2b_access1: pready=%b pslverr=%b prdata=%h, required 1/%b/%h",
               b_pready, b_pslverr, b_prdata, e.err, e.rdata);
    end
    @(posedge clk); #1;
    b_penable = 0; b_paddr = 32'hC; b_pwdata = 32'h2468_ACE0;
    @(negedge clk);
    n_tests++;
    if (b_pready !== 1'b0 || b_wr_pulse !== e.pulse) begin
      n_fail++;
      $display("FAIL b2b_setup2: pready=%b wr_pulse=%h, required 0 and %h", b_pready, b_wr_pulse, e.pulse);
    end
    @(posedge clk); #1 b_penable = 1;
    @(negedge clk);
    e = sb_q.pop_front();
    n_tests++;
    if (b_pready !== 1'b1 || b_pslverr !== e.err) begin
      n_fail++;
      $display("FAIL b2b_access2: pready=%b pslverr=%b, required 1/%b", b_pready, b_pslverr, e.err);
    end
    @(posedge clk); #1 b_psel = 0; b_penable = 0;
    @(negedge clk);
    n_tests++;
    if (b_wr_pulse !== e.pulse || b_reg_out[31:0] !== 32'h1357_9BDF ||
        b_reg_out[127:96] !== 32'h2468_ACE0) begin
      n_fail++;
      $display("FAIL b2b_commit: wr_pulse=%h reg0=%h reg3=%h, required %h 13579bdf 2468ace0",
               b_wr_pulse, b_reg_out[31:0], b_reg_out[127:96], e.pulse);
    end
  endtask

  task automatic test_abort();
    // psel dropped during wait states
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = BASE + 32'h14; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 psel = 0; penable = 0;
    @(negedge clk);
    n_tests++;
    if (pready !== 1'b0 || wr_pulse !== '0) begin
      n_fail++;
      $display("FAIL abort_psel_bus: pready=%b wr_pulse=%h, required 0 and 0", pready, wr_pulse);
    end
    @(negedge clk);
    n_tests++;
    if (reg_out !== model_flat() || wr_pulse !== '0) begin
      n_fail++;
      $display("FAIL abort_psel_nocommit: reg5=%h wr_pulse=%h, required %h and 0",
               reg_out[191:160], wr_pulse, model[5]);
    end
    apb_xfer(1'b1, BASE + 32'h14, 32'h5555_AAAA, 4'hF, 1'b0, "abort_psel_next");

    // reset asserted during the access phase
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = BASE + 32'h18; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1;
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0 ||
        reg_out !== '0 || wr_pulse !== '0) begin
      n_fail++;
      $display("FAIL abort_reset_outputs: pready=%b pslverr=%b prdata=%h regs_nonzero=%b wr_pulse=%h, required all 0",
               pready, pslverr, prdata, |reg_out, wr_pulse);
    end
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    @(posedge clk); #1;
    rstn = 1'b1; psel = 0; penable = 0;
    apb_xfer(1'b1, BASE + 32'h18, 32'h8765_4321, 4'hF, 1'b0, "abort_reset_next");
    n_tests++;
    if (reg_out[223:192] !== 32'h8765_4321) begin
      n_fail++;
      $display("FAIL abort_reset_reg6: got %h, required 87654321", reg_out[223:192]);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_strobes();
    test_errors();
    test_readonly();
    test_capture();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
